// File: rtl/calculate_new_capacity.sv
// Parking-slot update: toggles the one-hot selected spot in the availability map and
// registers the new map, event flags, location-error flag and free-spot count.
module calculate_new_capacity (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] park_location,
  input  logic [7:0] parking_capacity,
  output logic [7:0] new_capacity,
  output logic       car_entered,
  output logic       car_exited,
  output logic       loc_error,
  output logic [3:0] free_count
);

  logic       loc_zero;
  logic       loc_one_hot;
  logic       loc_multi;
  logic       sel_free;
  logic [7:0] cap_d;
  logic       entered_d;
  logic       exited_d;
  logic [3:0] count_d;

  // Clearing the lowest set bit leaves zero only for a single-bit value.
  always_comb begin
    loc_zero    = (park_location == 8'h00);
    loc_one_hot = !loc_zero && ((park_location & (park_location - 8'd1)) == 8'h00);
    loc_multi   = !loc_zero && !loc_one_hot;
  end

  always_comb begin
    sel_free  = |(parking_capacity & park_location);
    cap_d     = parking_capacity;
    entered_d = 1'b0;
    exited_d  = 1'b0;
    if (loc_one_hot) begin
      cap_d     = parking_capacity ^ park_location;
      entered_d = sel_free;
      exited_d  = !sel_free;
    end
  end

  always_comb begin
    count_d = 4'd0;
    for (int i = 0; i < 8; i++) begin
      count_d = count_d + {3'd0, cap_d[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      new_capacity <= 8'hFF;
      car_entered  <= 1'b0;
      car_exited   <= 1'b0;
      loc_error    <= 1'b0;
      free_count   <= 4'd8;
    end else begin
      new_capacity <= cap_d;
      car_entered  <= entered_d;
      car_exited   <= exited_d;
      loc_error    <= loc_multi;
      free_count   <= count_d;
    end
  end

endmodule

// File: tb/tb_calculate_new_capacity.sv
// Directed bench for calculate_new_capacity with hand-computed expected values.
module tb_calculate_new_capacity;

  logic       clk;
  logic       rst;
  logic [7:0] park_location;
  logic [7:0] parking_capacity;
  logic [7:0] new_capacity;
  logic       car_entered;
  logic       car_exited;
  logic       loc_error;
  logic [3:0] free_count;

  int checks;
  int errors;

  calculate_new_capacity dut (
    .clk              (clk),
    .rst              (rst),
    .park_location    (park_location),
    .parking_capacity (parking_capacity),
    .new_capacity     (new_capacity),
    .car_entered      (car_entered),
    .car_exited       (car_exited),
    .loc_error        (loc_error),
    .free_count       (free_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] cap, input logic ent,
                         input logic ext, input logic err, input logic [3:0] cnt);
    chk({tag, ".cap"}, new_capacity, cap);
    chk({tag, ".ent"}, {7'd0, car_entered}, {7'd0, ent});
    chk({tag, ".ext"}, {7'd0, car_exited}, {7'd0, ext});
    chk({tag, ".err"}, {7'd0, loc_error}, {7'd0, err});
    chk({tag, ".cnt"}, {4'd0, free_count}, {4'd0, cnt});
  endtask

  task automatic step(input string tag, input logic [7:0] loc, input logic [7:0] cap,
                      input logic [7:0] e_cap, input logic e_ent, input logic e_ext,
                      input logic e_err, input logic [3:0] e_cnt);
    @(negedge clk);
    park_location    = loc;
    parking_capacity = cap;
    @(posedge clk);
    #1;
    chk_all(tag, e_cap, e_ent, e_ext, e_err, e_cnt);
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    rst              = 1'b1;
    park_location    = 8'h01;
    parking_capacity = 8'h00;
    #2;
    chk_all("reset", 8'hFF, 1'b0, 1'b0, 1'b0, 4'd8);
    // Held across edges with live inputs present.
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset_hold", 8'hFF, 1'b0, 1'b0, 1'b0, 4'd8);
    @(negedge clk);
    rst = 1'b0;

    // Exits
    step("exit0", 8'h01, 8'hC0, 8'hC1, 1'b0, 1'b1, 1'b0, 4'd3);
    step("exit1", 8'h02, 8'hC1, 8'hC3, 1'b0, 1'b1, 1'b0, 4'd4);
    step("exit2", 8'h04, 8'hC0, 8'hC4, 1'b0, 1'b1, 1'b0, 4'd3);
    step("exit3", 8'h08, 8'hC3, 8'hCB, 1'b0, 1'b1, 1'b0, 4'd5);
    // Enters
    step("ent4", 8'h10, 8'h32, 8'h22, 1'b1, 1'b0, 1'b0, 4'd2);
    step("ent5", 8'h20, 8'hE6, 8'hC6, 1'b1, 1'b0, 1'b0, 4'd4);
    step("ent6", 8'h40, 8'hC7, 8'h87, 1'b1, 1'b0, 1'b0, 4'd4);
    step("ent7", 8'h80, 8'hE4, 8'h64, 1'b1, 1'b0, 1'b0, 4'd3);
    // Held inputs keep the flag asserted
    @(posedge clk);
    #1;
    chk_all("ent7_hold", 8'h64, 1'b1, 1'b0, 1'b0, 4'd3);
    // No event, multi-hot
    step("none", 8'h00, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0, 4'd4);
    step("multi", 8'h03, 8'hC0, 8'hC0, 1'b0, 1'b0, 1'b1, 4'd2);
    step("multi_ff", 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 4'd0);
    step("multi_hi", 8'h81, 8'h7E, 8'h7E, 1'b0, 1'b0, 1'b1, 4'd6);
    // Boundaries
    step("full", 8'h01, 8'hFE, 8'hFF, 1'b0, 1'b1, 1'b0, 4'd8);
    step("empty", 8'h80, 8'h80, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0);

    // Reset between edges takes effect without a clock
    step("pre_rst", 8'h08, 8'hC3, 8'hCB, 1'b0, 1'b1, 1'b0, 4'd5);
    #2;
    rst = 1'b1;
    #1;
    chk_all("mid_rst", 8'hFF, 1'b0, 1'b0, 1'b0, 4'd8);
    @(negedge clk);
    rst = 1'b0;
    step("post_rst", 8'h10, 8'h32, 8'h22, 1'b1, 1'b0, 1'b0, 4'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
